// File: rtl/seg7_pattern_decoder_if.sv
// Decoder output bundle: segment tap in, digit stream and word status out.
// master is the decoder side, slave the tap/consumer side.
interface seg7_pattern_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg;
  logic                out_ready;
  logic                out_valid;
  logic [3:0]          out_digit;
  logic [4*DIGITS-1:0] out_word;
  logic                word_done;
  logic                blank;
  logic                err_invalid;
  logic                overrun;

  modport master (
    input  seg, out_ready,
    output out_valid, out_digit, out_word,
    output word_done, blank, err_invalid, overrun
  );

  modport slave (
    output seg, out_ready,
    input  out_valid, out_digit, out_word,
    input  word_done, blank, err_invalid, overrun
  );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Debounces a 7-segment bus and decodes stable patterns back to hex digits.
// Define SEG7_DEC_ACTIVE_LOW_EN for common-anode (active-low) segment buses.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input logic CLK,
  input logic RST,
  seg7_pattern_decoder_if.master bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(DIGITS + 1);
  localparam int WW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
  localparam logic [DW-1:0] DIG_ONE  = DW'(1);

`ifdef SEG7_DEC_ACTIVE_LOW_EN
  // seg_q keeps the raw bus; all-ones is the dark display
  localparam logic [6:0] SEG_RST = 7'h7F;
  function automatic logic [6:0] pol(input logic [6:0] s);
    return ~s;
  endfunction
`else
  localparam logic [6:0] SEG_RST = 7'h00;
  function automatic logic [6:0] pol(input logic [6:0] s);
    return s;
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // {valid digit, blank, digit}
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: return 6'b10_0000;
      7'b0110000: return 6'b10_0001;
      7'b1101101: return 6'b10_0010;
      7'b1111001: return 6'b10_0011;
      7'b0110011: return 6'b10_0100;
      7'b1011011: return 6'b10_0101;
      7'b1011111: return 6'b10_0110;
      7'b1110000: return 6'b10_0111;
      7'b1111111: return 6'b10_1000;
      7'b1111011: return 6'b10_1001;
      7'b1110111: return 6'b10_1010;
      7'b0011111: return 6'b10_1011;
      7'b1001110: return 6'b10_1100;
      7'b0111101: return 6'b10_1101;
      7'b1001111: return 6'b10_1110;
      7'b1000111: return 6'b10_1111;
      7'b0000000: return 6'b01_0000;
      default:    return 6'b00_0000;
    endcase
  endfunction

  state_t        state;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [DW-1:0] digit_cnt;
  logic          changed;
  logic          accept;
  logic [5:0]    dec;

  // The edge that samples a new pattern already counts as sample one
  always_comb begin
    changed = bus.seg != seg_q;
    cnt_n   = CNT_ONE;
    unique case (state)
      SETTLE:  cnt_n = changed ? CNT_ONE : cnt + CNT_ONE;
      HOLD:    cnt_n = changed ? CNT_ONE : cnt;
      default: cnt_n = CNT_ONE;
    endcase
    accept = (state != HOLD || changed) && cnt_n == CNT_MAX;
    dec    = decode(pol(bus.seg));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      seg_q           <= SEG_RST;
      cnt             <= '0;
      digit_cnt       <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_digit   <= '0;
      bus.out_word    <= '0;
      bus.word_done   <= 1'b0;
      bus.blank       <= 1'b0;
      bus.err_invalid <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      seg_q           <= bus.seg;
      cnt             <= cnt_n;
      bus.word_done   <= 1'b0;
      bus.err_invalid <= 1'b0;
      bus.overrun     <= 1'b0;
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (accept || (state == HOLD && !changed)) state <= HOLD;
      else state <= SETTLE;
      if (accept) begin
        unique case (1'b1)
          dec[5]: begin
            bus.blank <= 1'b0;
            if (!bus.out_valid || bus.out_ready) begin
              bus.out_valid <= 1'b1;
              bus.out_digit <= dec[3:0];
              bus.out_word  <= WW'({bus.out_word, dec[3:0]});
              if (digit_cnt == DIG_LAST) begin
                bus.word_done <= 1'b1;
                digit_cnt     <= '0;
              end else begin
                digit_cnt <= digit_cnt + DIG_ONE;
              end
            end else begin
              bus.overrun <= 1'b1;
            end
          end
          dec[4]: begin
            bus.blank <= 1'b1;
            if (digit_cnt != '0) begin
              bus.word_done <= 1'b1;
              digit_cnt     <= '0;
            end
          end
          default: bus.err_invalid <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: directed scenarios plus randomized traffic
// compared every cycle against a run-length model of the decoder.
module tb_seg7_pattern_decoder;
  localparam int SC = 4;
  localparam int DG = 4;
  localparam int WW = 4 * DG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_pattern_decoder_if #(.DIGITS(DG)) bus ();

  seg7_pattern_decoder #(
    .STABLE_CYCLES(SC),
    .DIGITS(DG)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic int lookup(logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  // Model: a pattern is accepted on the edge where its run of identical
  // samples reaches SC; the run starts over after reset.
  int            m_run;
  bit            m_fresh;
  logic [6:0]    m_prev;
  int            m_cnt;
  logic          m_valid, m_wd, m_blank, m_err, m_ovr;
  logic [3:0]    m_digit;
  logic [WW-1:0] m_word;

  initial begin : model
    logic [6:0] s;
    logic       r;
    bit         ld_ok;
    int         idx;
    forever begin
      @(posedge clk);
      s = bus.seg;
      r = bus.out_ready;
      if (!rst_n) begin
        m_fresh = 1; m_run = 0; m_prev = '0; m_cnt = 0;
        m_valid = 0; m_digit = '0; m_word = '0;
        m_wd = 0; m_blank = 0; m_err = 0; m_ovr = 0;
      end else begin
        if (m_fresh || s != m_prev) m_run = 1;
        else m_run++;
        m_fresh = 0;
        m_prev  = s;
        ld_ok   = !m_valid || r;
        if (r) m_valid = 0;
        m_wd = 0; m_err = 0; m_ovr = 0;
        if (m_run == SC) begin
          idx = lookup(s);
          if (idx >= 0) begin
            m_blank = 0;
            if (ld_ok) begin
              m_valid = 1;
              m_digit = 4'(idx);
              m_word  = (m_word << 4) | WW'(idx);
              m_cnt++;
              if (m_cnt == DG) begin m_wd = 1; m_cnt = 0; end
            end else m_ovr = 1;
          end else if (s == 7'b0) begin
            m_blank = 1;
            if (m_cnt > 0) begin m_wd = 1; m_cnt = 0; end
          end else m_err = 1;
        end
      end
      #1;
      check("model",
        {bus.out_valid, bus.out_digit, bus.out_word, bus.word_done,
         bus.blank, bus.err_invalid, bus.overrun},
        {m_valid, m_digit, m_word, m_wd, m_blank, m_err, m_ovr});
    end
  end

  int v_cnt, wd_cnt, err_cnt, ovr_cnt;
  logic [3:0] last_digit;

  task automatic clr();
    v_cnt = 0; wd_cnt = 0; err_cnt = 0; ovr_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(logic [6:0] p, int n);
    @(negedge clk);
    bus.seg = p;
    repeat (n) begin
      tick();
      if (bus.out_valid) begin v_cnt++; last_digit = bus.out_digit; end
      wd_cnt  += int'(bus.word_done);
      err_cnt += int'(bus.err_invalid);
      ovr_cnt += int'(bus.overrun);
    end
  endtask

  initial begin : stim
    int sel, n;
    logic [6:0] p;
    bus.seg = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("reset_state",
      {bus.out_valid, bus.out_digit, bus.out_word, bus.word_done,
       bus.blank, bus.err_invalid, bus.overrun}, 64'h0);

    // Digit 3 held for 10 cycles: accepted on the fourth edge only
    @(negedge clk);
    bus.seg = 7'b1111001;
    rst_n = 1'b1;
    clr();
    repeat (3) begin tick(); v_cnt += int'(bus.out_valid); end
    check("t1_e3_valid", bus.out_valid, 1'b0);
    tick();
    v_cnt += int'(bus.out_valid);
    check("t1_e4_valid_digit", {bus.out_valid, bus.out_digit}, 5'h13);
    repeat (6) begin tick(); v_cnt += int'(bus.out_valid); end
    check("t1_once", v_cnt, 1);

    // Short glitch of 1 followed by 8
    clr();
    hold(7'b0110000, 2);
    hold(7'b1111111, 8);
    check("t2_count", v_cnt, 1);
    check("t2_digit", last_digit, 4'h8);

    // Flush the partial word, then 1,2,3,4 and a trailing blank
    hold(7'b0000000, 6);
    clr();
    hold(tbl[1], 6);
    hold(tbl[2], 6);
    hold(tbl[3], 6);
    hold(tbl[4], 6);
    check("t3_word", bus.out_word, 16'h1234);
    check("t3_wd", wd_cnt, 1);
    clr();
    hold(7'b0000000, 6);
    check("t3_blank_wd", wd_cnt, 0);
    check("t3_blank", bus.blank, 1'b1);

    // Consumer stalled: 7 stays, A is dropped
    @(negedge clk);
    bus.out_ready = 1'b0;
    clr();
    hold(tbl[7], 6);
    hold(tbl[10], 6);
    check("t4_digit", bus.out_digit, 4'h7);
    check("t4_ovr", ovr_cnt, 1);
    check("t4_word", bus.out_word[3:0], 4'h7);
    check("t4_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    tick();
    check("t4_drain", bus.out_valid, 1'b0);

    // Invalid pattern
    clr();
    hold(7'b1010101, 6);
    check("t5_err", err_cnt, 1);
    check("t5_valid", v_cnt, 0);

    // Single digit closed by blank, then reset mid-settle
    hold(7'b0000000, 6);
    clr();
    hold(tbl[5], 6);
    hold(7'b0000000, 6);
    check("t6_wd", wd_cnt, 1);
    check("t6_blank", bus.blank, 1'b1);
    @(negedge clk);
    bus.seg = tbl[2];
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_reset",
      {bus.out_valid, bus.out_digit, bus.out_word, bus.word_done,
       bus.blank, bus.err_invalid, bus.overrun}, 64'h0);
    tick();

    // Randomized traffic, checked by the model process every cycle
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) p = tbl[$urandom_range(0, 15)];
      else if (sel == 6) p = 7'b0;
      else if (sel == 7) p = 7'($urandom);
      else p = bus.seg;
      n = $urandom_range(1, 8);
      @(negedge clk);
      bus.seg = p;
      bus.out_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 59) != 0;
      repeat (n) begin
        @(negedge clk);
        bus.out_ready = $urandom_range(0, 2) != 0;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
